// File: rtl/freq_disp_fmt_pkg.sv
// Shared types and constants for the frequency display formatter.
// FREQ_FMT_ROUND_EN selects a 33-step rounding divide instead of 32-step truncation.
package freq_meter_pkg;

  localparam int DIG_NUM = 6;
  localparam int BIN_W   = 20;
  localparam int BCD_W   = 24;
  localparam int STEP_W  = 6;

`ifdef FREQ_FMT_ROUND_EN
  localparam int DIV_STEPS = 33;
`else
  localparam int DIV_STEPS = 32;
`endif

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_DIV  = 3'd1;
  localparam state_t ST_SAT  = 3'd2;
  localparam state_t ST_BCD  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/freq_disp_fmt_if.sv
// Bus between the measurement controller (master) and the display formatter (slave).
interface freq_disp_fmt_if;
  import freq_meter_pkg::*;

  logic [31:0]      freq;
  logic             freq_valid;
  logic [BIN_W-1:0] data;
  logic [BCD_W-1:0] bcd;
  logic             ovf;
  logic             out_valid;
  logic             busy;

  modport master (
    output freq, freq_valid,
    input  data, bcd, ovf, out_valid, busy
  );

  modport slave (
    input  freq, freq_valid,
    output data, bcd, ovf, out_valid, busy
  );

endinterface

// File: rtl/freq_disp_fmt_bcd_dabble_seq.sv
// Sequential 20-bit binary to 6-digit packed BCD converter (shift-add-3, one bit per cycle).
// done is high in the cycle whose closing edge completes the last iteration.
module bcd_dabble_seq
  import freq_meter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int SH_W = BCD_W + BIN_W;
  localparam logic [4:0] LAST_IT = 5'(BIN_W - 1);

  logic [SH_W-1:0] sh_p0;
  logic [SH_W-1:0] adj;
  logic [4:0]      cnt;
  logic            run;

  always_comb begin
    adj = sh_p0;
    for (int i = 0; i < DIG_NUM; i++) begin
      adj[BIN_W + 4*i +: 4] = dabble_adj(sh_p0[BIN_W + 4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 5'd1;
      if (cnt == LAST_IT) run <= 1'b0;
    end
  end

  // shift stage: adjust digits, then move one binary bit into the BCD field
  always_ff @(posedge clk) begin
    if (start) begin
      sh_p0 <= {{BCD_W{1'b0}}, bin};
    end else if (run) begin
      sh_p0 <= {adj[SH_W-2:0], 1'b0};
    end
  end

  assign bcd  = sh_p0[SH_W-1 -: BCD_W];
  assign done = run && (cnt == LAST_IT);

endmodule

// File: rtl/freq_disp_fmt.sv
// Frequency display formatter: Hz -> scaled, saturated value and packed BCD via a restoring divider.
// Build with FREQ_FMT_ROUND_EN to round to nearest instead of truncating.
module freq_disp_fmt
  import freq_meter_pkg::*;
#(
  parameter int unsigned DIV     = 1000,
  parameter int unsigned MAX_VAL = 999999
) (
  input logic            sys_clk,
  input logic            sys_rst,
  freq_disp_fmt_if.slave bus
);

  localparam int REM_W = BIN_W + 1;
  localparam logic [REM_W-1:0]     DIV_V    = REM_W'(DIV);
  localparam logic [DIV_STEPS-1:0] MAX_Q    = DIV_STEPS'(MAX_VAL);
  localparam logic [BIN_W-1:0]     MAX_V    = BIN_W'(MAX_VAL);
  localparam logic [STEP_W-1:0]    LAST_DIV = STEP_W'(DIV_STEPS - 1);
`ifdef FREQ_FMT_ROUND_EN
  localparam logic [DIV_STEPS-1:0] DIV_HALF = DIV_STEPS'(DIV / 2);
`endif

  if (DIV == 0 || DIV >= (1 << BIN_W) || MAX_VAL >= (1 << BIN_W)) begin : g_param_check
    $error("freq_disp_fmt: DIV must be 1..2^20-1 and MAX_VAL below 2^20");
  end

  function automatic logic [DIV_STEPS-1:0] dividend(input logic [31:0] f);
`ifdef FREQ_FMT_ROUND_EN
    return {1'b0, f} + DIV_HALF;
`else
    return f;
`endif
  endfunction

  // {ovf, value}: anything above the ceiling displays as the ceiling
  function automatic logic [BIN_W:0] saturate(input logic [DIV_STEPS-1:0] q);
    if (q > MAX_Q) return {1'b1, MAX_V};
    return {1'b0, q[BIN_W-1:0]};
  endfunction

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic                pend;
  logic [31:0]         pend_val;
  logic [DIV_STEPS-1:0] quo_p0;
  logic [REM_W-1:0]    rem_p0;
  logic [REM_W:0]      trial;
  logic [BIN_W:0]      sat_w;
  logic [BIN_W-1:0]    val_p1;
  logic                ovf_p1;
  logic [BCD_W-1:0]    cnv_bcd;
  logic                cnv_done;

  assign trial = {rem_p0, quo_p0[DIV_STEPS-1]} - {1'b0, DIV_V};
  assign sat_w = saturate(quo_p0);

  bcd_dabble_seq u_bcd (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (state == ST_SAT),
    .bin   (sat_w[BIN_W-1:0]),
    .bcd   (cnv_bcd),
    .done  (cnv_done)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      step          <= '0;
      pend          <= 1'b0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.data      <= '0;
      bus.bcd       <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.freq_valid && state != ST_IDLE) pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.freq_valid || pend) begin
            state    <= ST_DIV;
            step     <= '0;
            pend     <= 1'b0;
            bus.busy <= 1'b1;
          end
        end
        ST_DIV: begin
          step <= step + STEP_W'(1);
          if (step == LAST_DIV) state <= ST_SAT;
        end
        ST_SAT: state <= ST_BCD;
        ST_BCD: begin
          if (cnv_done) state <= ST_DONE;
        end
        ST_DONE: begin
          bus.data      <= val_p1;
          bus.bcd       <= cnv_bcd;
          bus.ovf       <= ovf_p1;
          bus.out_valid <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // capture / divide / saturate stages
  always_ff @(posedge sys_clk) begin
    if (bus.freq_valid && state != ST_IDLE) pend_val <= bus.freq;
    case (state)
      ST_IDLE: begin
        rem_p0 <= '0;
        if (bus.freq_valid) quo_p0 <= dividend(bus.freq);
        else if (pend)      quo_p0 <= dividend(pend_val);
      end
      ST_DIV: begin
        quo_p0 <= {quo_p0[DIV_STEPS-2:0], ~trial[REM_W]};
        rem_p0 <= trial[REM_W] ? {rem_p0[REM_W-2:0], quo_p0[DIV_STEPS-1]} : trial[REM_W-1:0];
      end
      ST_SAT: begin
        ovf_p1 <= sat_w[BIN_W];
        val_p1 <= sat_w[BIN_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_freq_disp_fmt.sv
// Scoreboard bench for freq_disp_fmt: directed vectors, expected results queued at stimulus time.
module tb_freq_disp_fmt;
  import freq_meter_pkg::*;

`ifdef FREQ_FMT_ROUND_EN
  localparam int ROUND = 1;
`else
  localparam int ROUND = 0;
`endif
  localparam int LAT = 55 + ROUND;

  typedef struct {
    logic [19:0] d;
    logic [23:0] b;
    logic        o;
    int          lat;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] f;
    logic [19:0] td; logic [23:0] tb; logic to;
    logic [19:0] rd; logic [23:0] rb; logic ro;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_push = 0;
  int   n_pulse = 0;
  exp_t sb[$];

  freq_disp_fmt_if bus();

  freq_disp_fmt #(.DIV(1000), .MAX_VAL(999999)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  vec_t vecs [12] = '{
    '{32'd50000000,  20'd50000,  24'h050000, 1'b0, 20'd50000,  24'h050000, 1'b0},
    '{32'd1999,      20'd1,      24'h000001, 1'b0, 20'd2,      24'h000002, 1'b0},
    '{32'd1499,      20'd1,      24'h000001, 1'b0, 20'd1,      24'h000001, 1'b0},
    '{32'hFFFFFFFF,  20'd999999, 24'h999999, 1'b1, 20'd999999, 24'h999999, 1'b1},
    '{32'd999,       20'd0,      24'h000000, 1'b0, 20'd1,      24'h000001, 1'b0},
    '{32'd123456789, 20'd123456, 24'h123456, 1'b0, 20'd123457, 24'h123457, 1'b0},
    '{32'd999999999, 20'd999999, 24'h999999, 1'b0, 20'd999999, 24'h999999, 1'b1},
    '{32'd1000000000,20'd999999, 24'h999999, 1'b1, 20'd999999, 24'h999999, 1'b1},
    '{32'd0,         20'd0,      24'h000000, 1'b0, 20'd0,      24'h000000, 1'b0},
    '{32'd1000,      20'd1,      24'h000001, 1'b0, 20'd1,      24'h000001, 1'b0},
    '{32'd500,       20'd0,      24'h000000, 1'b0, 20'd1,      24'h000001, 1'b0},
    '{32'd987654,    20'd987,    24'h000987, 1'b0, 20'd988,    24'h000988, 1'b0}
  };

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Strobe one value; optionally queue its expected result (lat 0 = latency not checked).
  task automatic send(input logic [31:0] f, input bit push, input logic [19:0] d,
                      input logic [23:0] b, input logic o, input int lat);
    exp_t e;
    @(negedge clk);
    bus.freq       = f;
    bus.freq_valid = 1'b1;
    if (push) begin
      e.d = d; e.b = b; e.o = o; e.lat = lat; e.cyc = cyc;
      sb.push_back(e);
      n_push++;
    end
    @(negedge clk);
    bus.freq_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      exp_t e;
      n_pulse++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out_valid: got data %0d, expected no strobe", bus.data);
      end else begin
        e = sb.pop_front();
        chk("data", bus.data, e.d);
        chk("bcd", bus.bcd, e.b);
        chk("ovf", bus.ovf, e.o);
        chk("busy_at_out", bus.busy, 1'b0);
        if (e.lat != 0) chk("latency", cyc - e.cyc, e.lat);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.freq       = '0;
    bus.freq_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", bus.data, 0);
    chk("rst_bcd", bus.bcd, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);

    foreach (vecs[i]) begin
      if (ROUND != 0) send(vecs[i].f, 1'b1, vecs[i].rd, vecs[i].rb, vecs[i].ro, LAT);
      else            send(vecs[i].f, 1'b1, vecs[i].td, vecs[i].tb, vecs[i].to, LAT);
      chk("busy_after_capture", bus.busy, 1'b1);
      drain();
    end

    // Arrivals while busy: 3000 is overwritten by 7000 before it can start.
    send(32'd42000, 1'b1, 20'd42, 24'h000042, 1'b0, LAT);
    repeat (8) @(negedge clk);
    send(32'd3000, 1'b0, '0, '0, 1'b0, 0);
    repeat (8) @(negedge clk);
    send(32'd7000, 1'b1, 20'd7, 24'h000007, 1'b0, 0);
    drain();
    repeat (60) @(negedge clk);

    // Reset mid-conversion with a pending value queued behind it.
    send(32'd123000, 1'b0, '0, '0, 1'b0, 0);
    repeat (8) @(negedge clk);
    send(32'd5000, 1'b0, '0, '0, 1'b0, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_data", bus.data, 0);
    chk("midrst_bcd", bus.bcd, 0);
    chk("midrst_ovf", bus.ovf, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    @(negedge clk);
    chk("midrst_busy_after", bus.busy, 0);
    repeat (80) @(negedge clk);

    send(32'd2500000, 1'b1, 20'd2500, 24'h002500, 1'b0, LAT);
    drain();

    chk("pulse_count", n_pulse, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
